// File: rtl/interboard_receive.sv
// Four-phase handshake receiver: collects four 6-bit chunks into a 24-bit frame and decodes it.
// Optional even-parity check over the whole frame when INTERBOARD_PARITY_EN is defined.
module interboard_receive #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       request,
    input  logic [5:0] interboard_data,
    output logic       ack,
    output logic       interboard_en,
    output logic       interboard_rst,
    output logic       interboard_move_dir,
    output logic [3:0] interboard_msg_type,
    output logic [4:0] interboard_block_x,
    output logic [2:0] interboard_block_y,
    output logic [5:0] interboard_card,
    output logic [2:0] interboard_sel_len,
    output logic       frame_err
);

    localparam logic [19:0] TmoLast = TIMEOUT_CYCLES - 20'd1;

    typedef enum logic [1:0] {
        StWaitReq = 2'd0,
        StWaitRel = 2'd1,
        StDeliver = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [19:0] tmo_q, tmo_d;
    logic [23:0] word_q, word_d;
    logic [21:0] fields_q, fields_d;
    logic        sync1_q, sync2_q;
    logic        ack_q, ack_d;
    logic        en_q, en_d;
    logic        rst_pulse_q, rst_pulse_d;
    logic        err_q, err_d;

    logic        req_s;
    logic        accept;
    logic        rel_seen;
    logic        tmo_run;
    logic        tmo_hit;
    logic        parity_ok;

    assign req_s = sync2_q;

    // Accept only after two consecutive high samples, so a pulse spanning one edge is ignored.
    assign accept   = (state_q == StWaitReq) && sync1_q && sync2_q;
    assign rel_seen = (state_q == StWaitRel) && !req_s;
    assign tmo_run  = (state_q == StWaitRel) || ((state_q == StWaitReq) && (cnt_q != 2'd0));
    assign tmo_hit  = tmo_run && (tmo_q >= TmoLast) && !accept && !rel_seen;

`ifdef INTERBOARD_PARITY_EN
    assign parity_ok = ~^word_q;
`else
    logic unused_parity;
    assign unused_parity = word_q[0];
    assign parity_ok     = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StWaitReq;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitReq: begin
                if (accept) begin
                    state_d = StWaitRel;
                end
            end
            StWaitRel: begin
                if (rel_seen) begin
                    state_d = (cnt_q == 2'd3) ? StDeliver : StWaitReq;
                end else if (tmo_hit) begin
                    state_d = StWaitReq;
                end
            end
            StDeliver: begin
                state_d = StWaitReq;
            end
            default: begin
                state_d = StWaitReq;
            end
        endcase
    end

    // Output and datapath next-state logic
    always_comb begin
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        word_d      = word_q;
        fields_d    = fields_q;
        ack_d       = ack_q;
        en_d        = 1'b0;
        rst_pulse_d = 1'b0;
        err_d       = 1'b0;

        if (accept) begin
            word_d = {word_q[17:0], interboard_data};
            ack_d  = 1'b1;
            tmo_d  = 20'd0;
        end else if (tmo_hit) begin
            ack_d = 1'b0;
            cnt_d = 2'd0;
            tmo_d = 20'd0;
            err_d = 1'b1;
        end else if (rel_seen) begin
            ack_d = 1'b0;
            cnt_d = (cnt_q == 2'd3) ? 2'd0 : cnt_q + 2'd1;
            tmo_d = tmo_q + 20'd1;
        end else if (tmo_run) begin
            tmo_d = tmo_q + 20'd1;
        end

        if (state_q == StDeliver) begin
            tmo_d = 20'd0;
            if (parity_ok) begin
                fields_d    = word_q[22:1];
                en_d        = 1'b1;
                rst_pulse_d = word_q[23];
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= 2'd0;
            tmo_q       <= 20'd0;
            word_q      <= 24'd0;
            fields_q    <= 22'd0;
            ack_q       <= 1'b0;
            en_q        <= 1'b0;
            rst_pulse_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sync1_q     <= request;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            word_q      <= word_d;
            fields_q    <= fields_d;
            ack_q       <= ack_d;
            en_q        <= en_d;
            rst_pulse_q <= rst_pulse_d;
            err_q       <= err_d;
        end
    end

    assign ack            = ack_q;
    assign interboard_en  = en_q;
    assign interboard_rst = rst_pulse_q;
    assign frame_err      = err_q;
    assign {interboard_move_dir, interboard_msg_type, interboard_block_x,
            interboard_block_y, interboard_card, interboard_sel_len} = fields_q;

endmodule
